branch_resolve: RTL

- Consumer end of the ALU flag interface (S/Z/V/N). Takes condition flags from the zero-compare ALU ops (GEZ/GTZ/LEZ/LTZ/EQ/NE) and decides whether a branch or jump is taken.
- Computes the target and counts delay slots, then drives a redirect handshake to the fetch stage.
- Sits between the EX stage and instruction fetch.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/br_target_calc.sv | 32 +++
 rtl/branch_resolve.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: branch-type and FSM encodings plus
// datapath widths used by the branch resolution slice.
package mips_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned JIDX_W     = 26;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JUMP = 2'd2,
    BR_JR   = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLOT  = 2'd1,
    S_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/br_target_calc.sv
// Combinational branch/jump target computation.
// Ports: br_type (encoding from mips_pkg), pc, imm (signed word offset),
//        jidx (jump index), rs_val (JR register) -> target_c.
module br_target_calc
  import mips_pkg::*;
(
  input  logic [1:0]        br_type,
  input  logic [XLEN-1:0]   pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [XLEN-1:0]   rs_val,
  output logic [XLEN-1:0]   target_c
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] imm_off;

  assign pc_plus4 = pc + XLEN'(INSN_BYTES);
  // Word offset sign-extended and scaled to bytes.
  assign imm_off  = {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};

  always_comb begin
    target_c = pc_plus4;
    case (br_type_e'(br_type))
      BR_COND: target_c = pc_plus4 + imm_off;
      BR_JUMP: target_c = {pc_plus4[XLEN-1:XLEN-4], jidx, 2'b00};
      BR_JR:   target_c = rs_val;
      default: target_c = pc_plus4;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch/jump resolution: decides taken from the ALU Z flag, latches the
// target, lets DELAY_SLOTS instructions through, then holds a redirect
// to fetch until accepted. Keeps saturating branch/taken statistics.
// Ports: clk, reset (sync, active-high); in_valid/in_ready EX handshake with
//        br_type, alu_z, pc, imm, jidx, rs_val; redirect_valid/redirect_pc/
//        redirect_ready to fetch; slot_branch_err pulse; br_count, taken_count.
module branch_resolve
  import mips_pkg::*;
#(
  parameter int unsigned DELAY_SLOTS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        br_type,
  input  logic              alu_z,
  input  logic [XLEN-1:0]   pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jidx,
  input  logic [XLEN-1:0]   rs_val,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  input  logic              redirect_ready,
  output logic              slot_branch_err,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count
);

  localparam int unsigned     SLOT_W    = 2;
  localparam logic [SLOT_W:0] SLOT_LAST = (SLOT_W+1)'(DELAY_SLOTS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic [XLEN-1:0]   target_c;
  logic              xfer_c, is_br_c, taken_c;
  logic              br_inc_c, taken_inc_c, err_c;

  br_target_calc u_tgt (
    .br_type  (br_type),
    .pc       (pc),
    .imm      (imm),
    .jidx     (jidx),
    .rs_val   (rs_val),
    .target_c (target_c)
  );

  assign xfer_c      = in_valid & in_ready;
  assign is_br_c     = (br_type_e'(br_type) != BR_NONE);
  assign redirect_pc = tgt_q;

  // Z=0 means the zero-compare condition held.
  always_comb begin
    taken_c = 1'b0;
    case (br_type_e'(br_type))
      BR_COND:       taken_c = ~alu_z;
      BR_JUMP, BR_JR: taken_c = 1'b1;
      default:       taken_c = 1'b0;
    endcase
  end

  // Next-state, target capture and counter/error strobes.
  always_comb begin
    state_d     = state_q;
    slot_cnt_d  = slot_cnt_q;
    tgt_d       = tgt_q;
    br_inc_c    = 1'b0;
    taken_inc_c = 1'b0;
    err_c       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer_c && is_br_c) begin
          br_inc_c = 1'b1;
          if (taken_c) begin
            taken_inc_c = 1'b1;
            tgt_d       = target_c;
            slot_cnt_d  = '0;
            state_d     = (DELAY_SLOTS == 0) ? S_REDIR : S_SLOT;
          end
        end
      end
      S_SLOT: begin
        // Branches in a slot are dropped and flagged, but still use up the slot.
        if (xfer_c) begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
          err_c      = is_br_c;
          if (({1'b0, slot_cnt_q} + (SLOT_W+1)'(1)) == SLOT_LAST) begin
            state_d = S_REDIR;
          end
        end
      end
      S_REDIR: begin
        if (redirect_valid && redirect_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, handshake outputs and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      slot_cnt_q      <= '0;
      tgt_q           <= '0;
      in_ready        <= 1'b1;
      redirect_valid  <= 1'b0;
      slot_branch_err <= 1'b0;
      br_count        <= '0;
      taken_count     <= '0;
    end else begin
      state_q         <= state_d;
      slot_cnt_q      <= slot_cnt_d;
      tgt_q           <= tgt_d;
      in_ready        <= (state_d != S_REDIR);
      redirect_valid  <= (state_d == S_REDIR);
      slot_branch_err <= err_c;
      if (br_inc_c && (br_count != CNT_MAX)) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (taken_inc_c && (taken_count != CNT_MAX)) begin
        taken_count <= taken_count + CNT_W'(1);
      end
    end
  end

endmodule
